// File: rtl/pic_int_gateway.sv
// Per-source interrupt gateway: tracks IDLE/PEND/ACTIVE for each synchronized
// source and presents the lowest pending source to the arbiter.
module pic_int_gateway #(
  parameter int INT_NUM  = 8,
  parameter int ID_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [INT_NUM-1:0]  int_sync_in,
  input  logic [INT_NUM-1:0]  int_trig_mode,
  input  logic [INT_NUM-1:0]  int_en,
  input  logic                claim_vld,
  input  logic                cmplt_vld,
  input  logic [ID_WIDTH-1:0] cmplt_id,
  output logic [INT_NUM-1:0]  int_pend,
  output logic [INT_NUM-1:0]  int_active,
  output logic                int_req,
  output logic [ID_WIDTH-1:0] int_req_id
);

  // Handshake: claim_vld and cmplt_vld are single-cycle pulses sampled on the
  // rising clk edge; a claim acts only while int_req=1 and targets int_req_id,
  // a complete acts only on a source that is ACTIVE.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PEND   = 2'b01,
    ST_ACTIVE = 2'b10
  } state_e;

  state_e             state_q [INT_NUM];
  state_e             state_d [INT_NUM];
  logic [INT_NUM-1:0] prev_q, prev_d;
  logic [INT_NUM-1:0] edge_lat_q, edge_lat_d;

  logic [INT_NUM-1:0] rise;
  logic [INT_NUM-1:0] claim_hit;
  logic [INT_NUM-1:0] cmplt_hit;

  always_comb begin
    int_pend   = '0;
    int_active = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      int_pend[i]   = (state_q[i] == ST_PEND);
      int_active[i] = (state_q[i] == ST_ACTIVE);
    end
  end

  assign int_req = |int_pend;

  // Descending scan so the lowest-numbered pending source wins.
  always_comb begin
    int_req_id = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (int_pend[i]) int_req_id = ID_WIDTH'(i);
    end
  end

  always_comb begin
    rise      = int_sync_in & ~prev_q;
    claim_hit = '0;
    cmplt_hit = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      claim_hit[i] = claim_vld & int_req & (int_req_id == ID_WIDTH'(i));
      cmplt_hit[i] = cmplt_vld & (cmplt_id == ID_WIDTH'(i));
    end
  end

  always_comb begin
    prev_d     = int_sync_in;
    edge_lat_d = edge_lat_q;
    for (int i = 0; i < INT_NUM; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (int_trig_mode[i] ? (rise[i] & int_en[i])
                               : (int_sync_in[i] & int_en[i])) begin
            state_d[i] = ST_PEND;
          end
        end
        ST_PEND: begin
          if (!int_en[i] || (!int_trig_mode[i] && !int_sync_in[i])) begin
            state_d[i] = ST_IDLE;
          end else if (claim_hit[i]) begin
            state_d[i] = ST_ACTIVE;
            if (int_trig_mode[i] && rise[i]) edge_lat_d[i] = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cmplt_hit[i]) begin
            edge_lat_d[i] = 1'b0;
            if (int_trig_mode[i]) begin
              state_d[i] = ((edge_lat_q[i] | rise[i]) & int_en[i]) ? ST_PEND : ST_IDLE;
            end else begin
              state_d[i] = (int_sync_in[i] & int_en[i]) ? ST_PEND : ST_IDLE;
            end
          end else if (!int_en[i]) begin
            edge_lat_d[i] = 1'b0;
          end else if (int_trig_mode[i] && rise[i]) begin
            edge_lat_d[i] = 1'b1;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < INT_NUM; i++) state_q[i] <= ST_IDLE;
      prev_q     <= '0;
      edge_lat_q <= '0;
    end else begin
      for (int i = 0; i < INT_NUM; i++) state_q[i] <= state_d[i];
      prev_q     <= prev_d;
      edge_lat_q <= edge_lat_d;
    end
  end

endmodule
